// File: rtl/cnn_param_loader_pkg.sv
// Shared types and default dimensions for the CNN parameter loader.
package cnn_pkg;

  localparam int unsigned IDX_W   = 16;
  localparam int unsigned NUM_IDX = 4;

  typedef logic [IDX_W-1:0]        idx_word_t;
  typedef idx_word_t [NUM_IDX-1:0] idx_t;

  typedef enum logic [3:0] {
    IDLE,
    L1W,
    L1B,
    L3W,
    L3B,
    L5W,
    L5B,
    ACT,
    COMPUTE
  } state_t;

  // Default network dimensions
  localparam int unsigned DEF_DATA_SIZE     = 64;
  localparam int unsigned DEF_L1_NUM_OUTPUT = 16;
  localparam int unsigned DEF_L1_NUM_INPUT  = 1;
  localparam int unsigned DEF_L1_KERNEL_DIM = 3;
  localparam int unsigned DEF_L1_INPUT_DIM  = 28;
  localparam int unsigned DEF_L3_NUM_OUTPUT = 32;
  localparam int unsigned DEF_L3_NUM_INPUT  = 16;
  localparam int unsigned DEF_L3_KERNEL_DIM = 3;
  localparam int unsigned DEF_L5_NUM_OUTPUT = 10;
  localparam int unsigned DEF_L5_NUM_INPUT  = 800;

  // Strobe bit positions inside the loader's strobe register
  localparam int unsigned NUM_STB = 7;
  localparam int unsigned STB_L5B = 0;
  localparam int unsigned STB_L5W = 1;
  localparam int unsigned STB_L3B = 2;
  localparam int unsigned STB_L3W = 3;
  localparam int unsigned STB_L1B = 4;
  localparam int unsigned STB_L1W = 5;
  localparam int unsigned STB_ACT = 6;

  typedef logic [NUM_STB-1:0] strobe_t;

  // Pack four dimension sizes into an index tuple (d3 outermost)
  function automatic idx_t make_lim(input int unsigned d3, input int unsigned d2,
                                    input int unsigned d1, input int unsigned d0);
    idx_t l;
    l[3] = IDX_W'(d3);
    l[2] = IDX_W'(d2);
    l[1] = IDX_W'(d1);
    l[0] = IDX_W'(d0);
    return l;
  endfunction

  // One-hot write strobe for the memory targeted by a load state
  function automatic strobe_t strobe_for(input state_t s);
    strobe_t st;
    st = '0;
    case (s)
      L1W:     st[STB_L1W] = 1'b1;
      L1B:     st[STB_L1B] = 1'b1;
      L3W:     st[STB_L3W] = 1'b1;
      L3B:     st[STB_L3B] = 1'b1;
      L5W:     st[STB_L5W] = 1'b1;
      L5B:     st[STB_L5B] = 1'b1;
      ACT:     st[STB_ACT] = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

  // Fixed load order; the image is always last, then the compute pulse
  function automatic state_t next_load(input state_t s);
    case (s)
      L1W:     return L1B;
      L1B:     return L3W;
      L3W:     return L3B;
      L3B:     return L5W;
      L5W:     return L5B;
      L5B:     return ACT;
      ACT:     return COMPUTE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cnn_param_loader_if.sv
// Host stream plus CNN load bus seen by the parameter loader.
interface cnn_param_loader_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) ();

  logic                 start;
  logic                 load_weights;
  logic [DATA_SIZE-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_SIZE-1:0] input_data;
  idx_t                 input_index;
  logic                 input_write_act;
  logic                 input_write_weights;
  logic                 input_write_bias;
  logic                 l3_write_weights;
  logic                 l3_write_bias;
  logic                 l5_write_weights;
  logic                 l5_write_bias;
  logic                 compute;
  logic                 busy;
  logic                 done;

  // Loader side
  modport master (
    input  start, load_weights, s_data, s_valid,
    output s_ready, input_data, input_index,
           input_write_act, input_write_weights, input_write_bias,
           l3_write_weights, l3_write_bias, l5_write_weights, l5_write_bias,
           compute, busy, done
  );

  // Host / network side
  modport slave (
    output start, load_weights, s_data, s_valid,
    input  s_ready, input_data, input_index,
           input_write_act, input_write_weights, input_write_bias,
           l3_write_weights, l3_write_bias, l5_write_weights, l5_write_bias,
           compute, busy, done
  );

endinterface

// File: rtl/nd_index_counter.sv
// Four cascaded 16-bit counters with runtime limits; idx[0] is innermost.
module nd_index_counter
  import cnn_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  idx_t lim_in,
  input  logic clr,
  input  logic en,
  output idx_t idx,
  output logic last
);

  idx_t               lim;
  idx_t               nxt;
  logic [NUM_IDX-1:0] at_max;
  logic               carry;

  // Ripple the increment from idx[0] outward, wrapping each digit at its limit
  always_comb begin
    carry = en;
    nxt   = idx;
    for (int unsigned k = 0; k < NUM_IDX; k++) begin
      at_max[k] = (idx[k] == lim[k] - IDX_W'(1));
      if (carry) nxt[k] = at_max[k] ? '0 : idx[k] + IDX_W'(1);
      carry = carry && at_max[k];
    end
    last = &at_max;
  end

  // Index and limit registers; load also restarts the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
      lim <= '0;
    end else if (load) begin
      idx <= '0;
      lim <= lim_in;
    end else if (clr) begin
      idx <= '0;
    end else begin
      idx <= nxt;
    end
  end

endmodule

// File: rtl/cnn_param_loader.sv
// Streams host words into the CNN load interface, walking each memory's index space.
module cnn_param_loader
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_SIZE     = DEF_DATA_SIZE,
  parameter int unsigned L1_NUM_OUTPUT = DEF_L1_NUM_OUTPUT,
  parameter int unsigned L1_NUM_INPUT  = DEF_L1_NUM_INPUT,
  parameter int unsigned L1_KERNEL_DIM = DEF_L1_KERNEL_DIM,
  parameter int unsigned L1_INPUT_DIM  = DEF_L1_INPUT_DIM,
  parameter int unsigned L3_NUM_OUTPUT = DEF_L3_NUM_OUTPUT,
  parameter int unsigned L3_NUM_INPUT  = DEF_L3_NUM_INPUT,
  parameter int unsigned L3_KERNEL_DIM = DEF_L3_KERNEL_DIM,
  parameter int unsigned L5_NUM_OUTPUT = DEF_L5_NUM_OUTPUT,
  parameter int unsigned L5_NUM_INPUT  = DEF_L5_NUM_INPUT
) (
  input logic               clk,
  input logic               reset,
  cnn_param_loader_if.master bus
);

  state_t               state;
  logic                 s_ready_q;
  logic [DATA_SIZE-1:0] data_q;
  idx_t                 index_q;
  strobe_t              strobe_q;
  logic                 compute_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_clr;
  logic                 cnt_en;
  idx_t                 cnt_lim;
  idx_t                 cnt_idx;
  logic                 cnt_last;

  // Unused index positions get a limit of 1 so they stay at 0
  function automatic idx_t limits_for(input state_t s);
    case (s)
      L1W:     return make_lim(L1_NUM_OUTPUT, L1_NUM_INPUT, L1_KERNEL_DIM, L1_KERNEL_DIM);
      L1B:     return make_lim(1, 1, 1, L1_NUM_OUTPUT);
      L3W:     return make_lim(L3_NUM_OUTPUT, L3_NUM_INPUT, L3_KERNEL_DIM, L3_KERNEL_DIM);
      L3B:     return make_lim(1, 1, 1, L3_NUM_OUTPUT);
      L5W:     return make_lim(1, 1, L5_NUM_OUTPUT, L5_NUM_INPUT);
      L5B:     return make_lim(1, 1, 1, L5_NUM_OUTPUT);
      ACT:     return make_lim(1, L1_NUM_INPUT, L1_INPUT_DIM, L1_INPUT_DIM);
      default: return make_lim(1, 1, 1, 1);
    endcase
  endfunction

  assign accept = bus.s_valid && s_ready_q;

  nd_index_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .lim_in (cnt_lim),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .idx    (cnt_idx),
    .last   (cnt_last)
  );

  // Counter control: reload limits on every state change, step on each accept
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = (state == COMPUTE);
    cnt_lim  = make_lim(1, 1, 1, 1);
    case (state)
      IDLE: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          cnt_lim  = limits_for(bus.load_weights ? L1W : ACT);
        end
      end
      COMPUTE: ;
      default: begin
        if (accept) begin
          if (cnt_last) begin
            cnt_load = 1'b1;
            cnt_lim  = limits_for(next_load(state));
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
    endcase
  end

  // Sequencer with registered bus outputs; strobes appear one cycle after accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      s_ready_q <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      strobe_q  <= '0;
      compute_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      strobe_q  <= '0;
      compute_q <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            state     <= bus.load_weights ? L1W : ACT;
            busy_q    <= 1'b1;
            s_ready_q <= 1'b1;
          end
        end
        COMPUTE: begin
          compute_q <= 1'b1;
          done_q    <= 1'b1;
          s_ready_q <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          if (accept) begin
            data_q   <= bus.s_data;
            index_q  <= cnt_idx;
            strobe_q <= strobe_for(state);
            if (cnt_last) begin
              state <= next_load(state);
              if (next_load(state) == COMPUTE) s_ready_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.s_ready             = s_ready_q;
  assign bus.input_data          = data_q;
  assign bus.input_index         = index_q;
  assign bus.input_write_act     = strobe_q[STB_ACT];
  assign bus.input_write_weights = strobe_q[STB_L1W];
  assign bus.input_write_bias    = strobe_q[STB_L1B];
  assign bus.l3_write_weights    = strobe_q[STB_L3W];
  assign bus.l3_write_bias       = strobe_q[STB_L3B];
  assign bus.l5_write_weights    = strobe_q[STB_L5W];
  assign bus.l5_write_bias       = strobe_q[STB_L5B];
  assign bus.compute             = compute_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;

endmodule

// File: tb/tb_cnn_param_loader.sv
// Directed bench for cnn_param_loader with an expected-strobe queue.
module tb_cnn_param_loader;
  import cnn_pkg::*;

  // Expected strobe vectors, order {act, l1w, l1b, l3w, l3b, l5w, l5b}
  localparam logic [6:0] K_ACT = 7'b1000000;
  localparam logic [6:0] K_W1  = 7'b0100000;
  localparam logic [6:0] K_B1  = 7'b0010000;
  localparam logic [6:0] K_W3  = 7'b0001000;
  localparam logic [6:0] K_B3  = 7'b0000100;
  localparam logic [6:0] K_W5  = 7'b0000010;
  localparam logic [6:0] K_B5  = 7'b0000001;

  typedef struct packed {
    logic [6:0]  stb;
    logic [63:0] data;
    idx_t        idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_param_loader_if #(.DATA_SIZE(64)) bus ();

  cnn_param_loader #(
    .DATA_SIZE(64), .L1_NUM_OUTPUT(16), .L1_NUM_INPUT(1), .L1_KERNEL_DIM(3),
    .L1_INPUT_DIM(28), .L3_NUM_OUTPUT(32), .L3_NUM_INPUT(16), .L3_KERNEL_DIM(3),
    .L5_NUM_OUTPUT(10), .L5_NUM_INPUT(800)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t        q[$];
  logic [63:0] exp_data;
  int          kc[7];
  int          comp_cnt;
  int          cyc      = 0;
  int          last_act = -100;
  logic        acc_prev = 1'b0;
  logic        busy_chk = 1'b0;
  logic        mon_en   = 1'b0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] k, input int a3, input int a2, input int a1, input int a0);
    exp_t e;
    e.stb    = k;
    e.data   = exp_data;
    e.idx[3] = 16'(a3);
    e.idx[2] = 16'(a2);
    e.idx[1] = 16'(a1);
    e.idx[0] = 16'(a0);
    q.push_back(e);
    exp_data++;
  endtask

  task automatic gen_act();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) push(K_ACT, 0, 0, r, c);
  endtask

  task automatic gen_full();
    for (int o = 0; o < 16; o++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) push(K_W1, o, 0, r, c);
    for (int o = 0; o < 16; o++) push(K_B1, 0, 0, 0, o);
    for (int o = 0; o < 32; o++)
      for (int i = 0; i < 16; i++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) push(K_W3, o, i, r, c);
    for (int o = 0; o < 32; o++) push(K_B3, 0, 0, 0, o);
    for (int o = 0; o < 10; o++)
      for (int i = 0; i < 800; i++) push(K_W5, 0, 0, o, i);
    for (int o = 0; o < 10; o++) push(K_B5, 0, 0, 0, o);
    gen_act();
  endtask

  task automatic clear_stats();
    q.delete();
    for (int b = 0; b < 7; b++) kc[b] = 0;
    comp_cnt = 0;
  endtask

  // Monitor: latency, strobe content, compute/done timing
  always @(negedge clk) begin
    logic [6:0] stb;
    exp_t       e;
    stb = {bus.input_write_act, bus.input_write_weights, bus.input_write_bias,
           bus.l3_write_weights, bus.l3_write_bias, bus.l5_write_weights, bus.l5_write_bias};
    if (mon_en) begin
      cyc++;
      if (acc_prev || stb != 7'd0) check_val("strobe_latency", 256'(stb != 7'd0), 256'(acc_prev));
      if (stb != 7'd0) begin
        if (q.size() == 0) begin
          check_val("unexpected_strobe", 256'(stb), 256'(0));
        end else begin
          e = q.pop_front();
          check_val("strobe_word", {stb, bus.input_data, bus.input_index}, e);
        end
        for (int b = 0; b < 7; b++) if (stb[b]) kc[b]++;
        if (stb[6]) last_act = cyc;
      end
      if (bus.compute || bus.done) begin
        check_val("done_with_compute", 256'(bus.done), 256'(bus.compute));
        check_val("compute_after_act", 256'(cyc - last_act), 256'(1));
        check_val("busy_at_compute", 256'(bus.busy), 256'(1));
        comp_cnt++;
        busy_chk = 1'b1;
      end else if (busy_chk) begin
        busy_chk = 1'b0;
        check_val("busy_drop", 256'(bus.busy), 256'(0));
      end
      acc_prev = bus.s_valid && bus.s_ready && reset;
    end
  end

  task automatic run_words(input int n, input bit toggle);
    int  sent;
    int  c;
    bit  acc;
    sent = 0;
    c    = 0;
    while (sent < n && c < 2 * n + 20) begin
      bus.s_valid = toggle ? ~c[0] : 1'b1;
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        bus.s_data = bus.s_data + 64'd1;
      end
      c++;
    end
    bus.s_valid = 1'b0;
    check_val("words_accepted", 256'(sent), 256'(n));
  endtask

  task automatic do_start(input logic lw);
    bus.load_weights = lw;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_compute(input int target);
    for (int i = 0; i < 20 && comp_cnt < target; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_val("compute_count", 256'(comp_cnt), 256'(target));
  endtask

  // Reset with s_valid high, then check every output is cleared
  task automatic abort_with_reset(input string tag);
    bus.s_valid = 1'b1;
    reset       = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val(tag, {bus.input_write_act, bus.input_write_weights, bus.input_write_bias,
                    bus.l3_write_weights, bus.l3_write_bias, bus.l5_write_weights,
                    bus.l5_write_bias, bus.compute, bus.busy, bus.done, bus.s_ready,
                    bus.input_data, bus.input_index}, 256'(0));
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.load_weights = 1'b0;
    bus.s_data       = '0;
    bus.s_valid      = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("reset_outputs", {bus.input_write_act, bus.input_write_weights, bus.input_write_bias,
                                bus.l3_write_weights, bus.l3_write_bias, bus.l5_write_weights,
                                bus.l5_write_bias, bus.compute, bus.busy, bus.done, bus.s_ready,
                                bus.input_data, bus.input_index}, 256'(0));
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Abort at word 100 of L3W
    exp_data   = 64'd0;
    bus.s_data = 64'd0;
    gen_full();
    do_start(1'b1);
    check_val("busy_after_start", 256'(bus.busy), 256'(1));
    run_words(260, 1'b0);
    abort_with_reset("reset_mid_l3w");
    check_val("l3w_before_abort", 256'(kc[3]), 256'(100));
    clear_stats();

    // Full load with incrementing data
    exp_data   = 64'd0;
    bus.s_data = 64'd0;
    gen_full();
    do_start(1'b1);
    run_words(13594, 1'b0);
    wait_compute(1);
    check_val("full_kind_counts",
              {16'(kc[6]), 16'(kc[5]), 16'(kc[4]), 16'(kc[3]), 16'(kc[2]), 16'(kc[1]), 16'(kc[0])},
              {16'd784, 16'd144, 16'd16, 16'd4608, 16'd32, 16'd8000, 16'd10});
    check_val("full_queue_drained", 256'(q.size()), 256'(0));
    check_val("idle_not_ready", 256'(bus.s_ready), 256'(0));
    clear_stats();

    // Image only, with a stray start in the middle of ACT
    exp_data   = 64'd5000;
    bus.s_data = 64'd5000;
    gen_act();
    do_start(1'b0);
    run_words(400, 1'b0);
    do_start(1'b1);
    run_words(384, 1'b0);
    wait_compute(1);
    check_val("image_kind_counts",
              {16'(kc[6]), 16'(kc[5]), 16'(kc[4]), 16'(kc[3]), 16'(kc[2]), 16'(kc[1]), 16'(kc[0])},
              {16'd784, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});
    check_val("image_queue_drained", 256'(q.size()), 256'(0));
    clear_stats();

    // s_valid toggling during L1B
    exp_data   = 64'd0;
    bus.s_data = 64'd0;
    gen_full();
    do_start(1'b1);
    run_words(144, 1'b0);
    run_words(16, 1'b1);
    run_words(4, 1'b0);
    abort_with_reset("reset_after_l1b");
    check_val("l1b_count", 256'(kc[4]), 256'(16));
    check_val("l3w_after_l1b", 256'(kc[3]), 256'(4));
    clear_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL timeout obs=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cnn_param_loader.md
Name: cnn_param_loader

Overview:
- Host-side transmitter that drives the CNN top's load interface: the data bus, the four 16-bit indices, the seven write strobes and the compute pulse.
- Accepts a flat valid/ready stream of 64-bit words from the host.
- Walks nested index counters for each target memory in a fixed order, then issues one compute pulse.
- Sits between the host/testbench DMA and the network top.

Parameters:
- DATA_SIZE, 64, width of the data words.
- L1_NUM_OUTPUT, 16, number of conv1 output channels.
- L1_NUM_INPUT, 1, number of conv1 input channels.
- L1_KERNEL_DIM, 3, conv1 kernel side.
- L1_INPUT_DIM, 28, side of the image.
- L3_NUM_OUTPUT, 32, number of conv2 output channels.
- L3_NUM_INPUT, 16, number of conv2 input channels.
- L3_KERNEL_DIM, 3, conv2 kernel side.
- L5_NUM_OUTPUT, 10, number of FC outputs.
- L5_NUM_INPUT, 800, number of FC inputs.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load sequence; sampled only in IDLE.
- load_weights  in  1  sampled with start; 1 = full parameter load plus image, 0 = image only.
- s_data  in  DATA_SIZE  host word.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts a word this cycle.
- input_data  out  DATA_SIZE  registered data to the top.
- input_index  out  4x16  registered indices [3:0] to the top.
- input_write_act, input_write_weights, input_write_bias  out  1 each  conv1 strobes.
- l3_write_weights, l3_write_bias  out  1 each  conv2 strobes.
- l5_write_weights, l5_write_bias  out  1 each  FC strobes.
- compute  out  1  one-cycle start pulse to the scheduler.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (reset=0 at a clk edge) forces the following, including mid-sequence; all index counters clear and any partial load is abandoned:
  - state IDLE;
  - all strobes, compute, done, busy and s_ready = 0;
  - input_data = 0 and all input_index = 0.
- State order with load_weights=1, word counts, and index mapping (unused indices driven 0):
  - L1W, 144 words: idx3=out, idx2=in, idx1=row, idx0=col.
  - L1B, 16 words: idx0=out.
  - L3W, 4608 words: same mapping as L1W.
  - L3B, 32 words: idx0=out.
  - L5W, 8000 words: idx1=out, idx0=in.
  - L5B, 10 words: idx0=out.
  - ACT, 784 words: idx2=channel, idx1=row, idx0=col.
  - Then COMPUTE, then IDLE.
- With load_weights=0, start goes IDLE->ACT directly.
- Count order: idx0 is innermost and wraps to 0 at its dimension limit with a carry into the next index. The last word of a state is the one with all indices at their maxima; accepting it moves to the next state.
- s_ready = 1 in all load states, 0 in IDLE and COMPUTE.
- Handshake: a word is accepted in cycle N when s_valid && s_ready.
  - In cycle N+1 exactly one strobe for the current target is high, with input_data = the accepted word and input_index = that word's index tuple.
  - Latency is 1 cycle. Strobes are single-cycle; back-to-back accepts give back-to-back strobes.
  - s_valid=0 stalls the sequence: no strobe, counters hold.
  - input_data and input_index hold their last values while no strobe is asserted.
- COMPUTE is entered the cycle after the last ACT word is accepted, after that word's strobe.
  - compute=1 for exactly one cycle, and done=1 in the same cycle.
  - Next state is IDLE; busy drops one cycle later.
- start while busy is ignored; start and a reset in the same cycle resolves to reset.
- Index counters are 16-bit unsigned; all dimensions are below 2^16, so no overflow is possible.

Decomposition:
- Shared package cnn_pkg: state enum (IDLE, L1W, L1B, L3W, L3B, L5W, L5B, ACT, COMPUTE), layer dimension constants, and a 4x16 index typedef.
- One sub-module, nd_index_counter:
  - 4 cascaded 16-bit counters with runtime limits, clear and enable inputs, and a last flag;
  - the loader loads the per-state limits into it on each state change.

Test Plan:
- Reset low mid-L3W (word 100 of 4608), with s_valid held high -> next cycle all outputs 0 and state IDLE; a new start with load_weights=1 restarts at L1W, index (0,0,0,0).
- Full load with s_data = an incrementing count and s_valid always high:
  - 144+16+4608+32+8000+10+784 = 13594 strobes, each 1 cycle after its accept;
  - first L3 weight word = 160 with index (0,0,0,0); last L5W word has idx1=9, idx0=799;
  - a single compute pulse one cycle after the last act strobe.
- Image-only load (load_weights=0) -> no weight/bias strobes; 784 input_write_act strobes, the last with index (0,27,27); then compute and done pulse together.
- s_valid toggling 1,0,1,0 during L1B -> strobes on alternate cycles, the index advances only on accepts, and bias indices run 0..15 with no gaps.
- start pulsed during ACT -> ignored; the sequence completes normally with exactly one compute pulse.
- Carry check in L1W: after the word at (0,0,2,2) the next index is (1,0,0,0); in L3W, after (0,15,2,2) the next is (1,0,0,0).
